adc_replay_unit: RTL and testbench



---
 rtl/adc_replay_unit.sv | 207 ++++++++++++++++++++
 tb/tb_adc_replay_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_replay_unit.sv
// adc_replay_unit: capture-and-replay engine for the UART command path.
// A header byte selects the sample source (UART bytes or an internal ramp)
// and the sample count; the captured bytes are then replayed byte by byte
// through the UART transmitter handshake, and completion is flagged on done.
module adc_replay_unit #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activate,
    output logic       done,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_CAP_UART = 3'd2,
        ST_CAP_ADC  = 3'd3,
        ST_SEND     = 3'd4,
        ST_WAIT_TX  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Sample storage: one write port, combinational read.
    logic [7:0] mem [0:DEPTH-1];

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic [CW-1:0]   idx_r;
    logic [CW-1:0]   idx_next_s;
    // Only the sample count derived from the header is kept; the source
    // select bit is consumed in the cycle the header arrives.
    logic [CW-1:0]   n_r;
    logic [CW-1:0]   n_next_s;
    logic [7:0]      ramp_r;
    logic [7:0]      ramp_next_s;
    logic            mem_we_s;
    logic [7:0]      mem_wdata_s;
    logic            tx_start_next_s;
    logic [7:0]      tx_data_next_s;
    logic            done_next_s;
    logic [CW-1:0]   cnt_inc_s;
    logic [CW-1:0]   idx_inc_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;

    assign cnt_inc_s = cnt_r + CW'(1'b1);
    assign idx_inc_s = idx_r + CW'(1'b1);
    assign wr_addr_s = cnt_r[ADDR_WIDTH-1:0];
    assign rd_addr_s = idx_r[ADDR_WIDTH-1:0];

    // Next-state, counter, RAM-write and output-next logic.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        idx_next_s      = idx_r;
        n_next_s        = n_r;
        ramp_next_s     = ramp_r;
        mem_we_s        = 1'b0;
        mem_wdata_s     = 8'h00;
        tx_start_next_s = 1'b0;
        tx_data_next_s  = tx_data;

        case (state_r)
            ST_IDLE: begin
                if (activate) begin
                    state_next_s = ST_HEADER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_HEADER: begin
                if (!activate) begin
                    state_next_s = ST_IDLE;
                end else if (rx_ready) begin
                    n_next_s   = CW'(rx_data[6:0]) + CW'(1'b1);
                    cnt_next_s = '0;
                    if (rx_data[7]) begin
                        state_next_s = ST_CAP_ADC;
                    end else begin
                        state_next_s = ST_CAP_UART;
                    end
                end else begin
                    state_next_s = ST_HEADER;
                end
            end

            ST_CAP_UART: begin
                if (!activate) begin
                    state_next_s = ST_IDLE;
                end else if (rx_ready) begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = rx_data;
                    cnt_next_s  = cnt_inc_s;
                    if (cnt_inc_s == n_r) begin
                        idx_next_s   = '0;
                        state_next_s = ST_SEND;
                    end else begin
                        state_next_s = ST_CAP_UART;
                    end
                end else begin
                    state_next_s = ST_CAP_UART;
                end
            end

            ST_CAP_ADC: begin
                // An abort cycle neither writes nor advances the ramp.
                if (!activate) begin
                    state_next_s = ST_IDLE;
                end else begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = ramp_r;
                    ramp_next_s = ramp_r + 8'd1;
                    cnt_next_s  = cnt_inc_s;
                    if (cnt_inc_s == n_r) begin
                        idx_next_s   = '0;
                        state_next_s = ST_SEND;
                    end else begin
                        state_next_s = ST_CAP_ADC;
                    end
                end
            end

            ST_SEND: begin
                if (!activate) begin
                    state_next_s = ST_IDLE;
                end else begin
                    tx_data_next_s  = mem[rd_addr_s];
                    tx_start_next_s = 1'b1;
                    state_next_s    = ST_WAIT_TX;
                end
            end

            ST_WAIT_TX: begin
                // tx_done is honoured even in the tx_start cycle itself.
                if (!activate) begin
                    state_next_s = ST_IDLE;
                end else if (tx_done) begin
                    idx_next_s = idx_inc_s;
                    if (idx_inc_s == n_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SEND;
                    end
                end else begin
                    state_next_s = ST_WAIT_TX;
                end
            end

            ST_DONE: begin
                if (!activate) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end

            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        done_next_s = (state_next_s == ST_DONE);
    end

    // State, counters, ramp and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            idx_r    <= '0;
            n_r      <= '0;
            ramp_r   <= 8'h00;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            idx_r    <= idx_next_s;
            n_r      <= n_next_s;
            ramp_r   <= ramp_next_s;
            tx_start <= tx_start_next_s;
            tx_data  <= tx_data_next_s;
            done     <= done_next_s;
        end
    end

    // Sample RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_addr_s] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_adc_replay_unit.sv
// Self-checking bench for adc_replay_unit: directed and randomized runs
// compared against a byte-sequence reference model.
module tb_adc_replay_unit;

    logic       clk;
    logic       reset;
    logic       activate;
    logic       done;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;

    int total;
    int bad;
    int ramp_m;
    logic [7:0] fixed_q[$];

    adc_replay_unit #(.ADDR_WIDTH(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .activate (activate),
        .done     (done),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for tx_start, optionally toggling inputs that must be ignored.
    task automatic wait_start(input bit noise, input bit rx_noise, output int cyc);
        cyc = 0;
        while (tx_start !== 1'b1 && cyc < 400) begin
            if (noise) begin
                tx_done = 1'($urandom);
                if (rx_noise) begin
                    rx_ready = 1'($urandom);
                    rx_data  = 8'($urandom);
                end
            end
            tick();
            cyc++;
        end
        tx_done  = 1'b0;
        rx_ready = 1'b0;
    endtask

    // pat: 0 random bytes, 1 byte i at position i, 2 bytes from fixed_q.
    task automatic do_run(input logic [7:0] hdr, input int pat, input bit noise);
        int n;
        int lat;
        int d;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        n = int'(hdr[6:0]) + 1;
        activate = 1'b1;
        tick();
        rx_ready = 1'b1;
        rx_data  = hdr;
        tick();
        rx_ready = 1'b0;
        if (hdr[7] == 1'b0) begin
            for (int i = 0; i < n; i++) begin
                if (pat == 1)      b = 8'(i);
                else if (pat == 2) b = fixed_q[i];
                else               b = 8'($urandom);
                exp_q.push_back(b);
                if (noise && $urandom_range(0, 1) == 1) begin
                    tx_done = 1'b1;
                    tick();
                    tx_done = 1'b0;
                end
                rx_ready = 1'b1;
                rx_data  = b;
                tick();
                rx_ready = 1'b0;
            end
            wait_start(noise, 1'b1, lat);
            chk("uart_to_tx_latency", 32'(lat), 32'd1);
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back(8'(ramp_m + i));
            ramp_m = (ramp_m + n) % 256;
            wait_start(noise, 1'b0, lat);
            chk("adc_capture_cycles", 32'(lat), 32'(n + 1));
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                wait_start(noise, 1'b1, lat);
                chk("tx_done_to_start", 32'(lat), 32'd1);
            end
            chk("tx_data", 32'(tx_data), 32'(exp_q[i]));
            d = noise ? $urandom_range(0, 3) : 0;
            for (int k = 0; k < d; k++) begin
                rx_ready = noise;
                rx_data  = 8'($urandom);
                tick();
                rx_ready = 1'b0;
                chk("tx_start_width", 32'(tx_start), 32'd0);
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("start_after_done", 32'(tx_start), 32'd0);
            chk("tx_data_hold", 32'(tx_data), 32'(exp_q[i]));
            chk("done_flag", 32'(done), 32'(i == n - 1));
        end
        for (int k = 0; k < 3; k++) begin
            rx_ready = noise;
            rx_data  = 8'($urandom);
            tick();
            rx_ready = 1'b0;
            chk("done_hold", 32'(done), 32'd1);
            chk("no_start_in_done", 32'(tx_start), 32'd0);
        end
        activate = 1'b0;
        tick();
        chk("done_drop", 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        total    = 0;
        bad      = 0;
        ramp_m   = 0;
        reset    = 1'b0;
        activate = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        tx_done  = 1'b0;
        repeat (3) tick();
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_tx_start", 32'(tx_start), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b1;
        tick();

        // Reset asserted in the middle of a ramp capture.
        activate = 1'b1;
        tick();
        rx_ready = 1'b1;
        rx_data  = 8'h8F;
        tick();
        rx_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("midcap_rst_done", 32'(done), 32'd0);
        chk("midcap_rst_start", 32'(tx_start), 32'd0);
        chk("midcap_rst_data", 32'(tx_data), 32'd0);
        activate = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ramp_m = 0;

        // Ramp replay twice: 00..03 then 04..07.
        do_run(8'h83, 0, 1'b0);
        do_run(8'h83, 0, 1'b0);

        // UART replay of three fixed bytes.
        fixed_q = '{8'hA5, 8'h3C, 8'hFF};
        do_run(8'h02, 2, 1'b0);

        // Full-depth UART replay 0x00..0x7F.
        do_run(8'h7F, 1, 1'b0);

        // Reset while tx_start is high drops outputs at once.
        activate = 1'b1;
        tick();
        rx_ready = 1'b1;
        rx_data  = 8'h00;
        tick();
        rx_data  = 8'h5A;
        tick();
        rx_ready = 1'b0;
        wait_start(1'b0, 1'b0, lat);
        chk("pre_reset_data", 32'(tx_data), 32'h5A);
        reset = 1'b0;
        #1;
        chk("async_rst_start", 32'(tx_start), 32'd0);
        chk("async_rst_data", 32'(tx_data), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        activate = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ramp_m = 0;

        // Walk the ramp to 0xFE, then check the wrap.
        do_run(8'hFF, 0, 1'b0);
        do_run(8'hFD, 0, 1'b0);
        do_run(8'hFF, 0, 1'b0);

        // Abort in WAIT_TX, with tx_done in the same cycle as the drop.
        activate = 1'b1;
        tick();
        rx_ready = 1'b1;
        rx_data  = 8'h01;
        tick();
        rx_data  = 8'h11;
        tick();
        rx_data  = 8'h22;
        tick();
        rx_ready = 1'b0;
        wait_start(1'b0, 1'b0, lat);
        chk("abort_first_byte", 32'(tx_data), 32'h11);
        tick();
        activate = 1'b0;
        tx_done  = 1'b1;
        tick();
        tx_done  = 1'b0;
        chk("abort_start", 32'(tx_start), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (tx_start === 1'b1 || done === 1'b1) pulses++;
        end
        chk("abort_quiet", 32'(pulses), 32'd0);
        do_run(8'h03, 0, 1'b0);

        // Randomized runs with ignored-input noise.
        for (int r = 0; r < 10; r++) begin
            do_run(8'($urandom), 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
